// File: rtl/dotprod_stream_if.sv
// dotprod_stream_if: input beat stream and result stream of dotprod_stream.
//
// Handshake: a beat moves when in_valid && in_ready are both high at a rising
// clk edge, and a result moves when out_valid && out_ready are both high at a
// rising edge. Once raised, out_valid stays high and out_data/out_sat stay
// stable until the result moves. in_a/in_b matter only on a beat transfer.
// The master modport is the producer/consumer side and the slave modport is
// the dot-product engine.
interface dotprod_stream_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int OUT_W  = 32
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   in_a;
    logic [LANES*DATA_W-1:0]   in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_W-1:0]          out_data;
    logic                      out_sat;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/dotprod_stream.sv
// dotprod_stream: streaming signed dot product of two IN_DIM-element vectors.
// The engine takes LANES element pairs per beat over BEATS beats, multiplies
// them (stage 1), adds the lane products (stage 2) and accumulates them at
// full precision. The result is held until the consumer takes it.
//
// Optional feature: define DOTPROD_STREAM_SAT_EN to clip the result to the
// OUT_W signed range and flag clipping on out_sat. Without the macro the
// result is the low OUT_W bits of the accumulator and out_sat stays 0.
//
// dbg_state shows the control state (0 ACCEPT, 1 DRAIN, 2 HOLD).
module dotprod_stream #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 8,
    parameter int LANES  = 4,
    parameter int OUT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    dotprod_stream_if.slave   bus,
    output logic [1:0]        dbg_state
);

    localparam int ACC_W  = 2*DATA_W + $clog2(IN_DIM) + 1;
    localparam int BEATS  = (IN_DIM + LANES - 1) / LANES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = 2*DATA_W;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        DRAIN  = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          beat_cnt;
    logic                      drain_cnt;
    logic                      in_fire;
    logic                      out_fire;
    logic                      last_beat;

    logic signed [PROD_W-1:0]  prod_c  [LANES];
    logic signed [PROD_W-1:0]  s1_prod [LANES];
    logic                      s1_valid;
    logic                      s1_first;

    logic signed [ACC_W-1:0]   sum_c;
    logic signed [ACC_W-1:0]   s2_sum;
    logic                      s2_valid;
    logic                      s2_first;

    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;

    logic [OUT_W-1:0]          res_data;
    logic                      res_sat;

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign dbg_state = state;

    // Lane products; lanes past the end of the vector on the final beat are
    // forced to zero so whatever sits on those input bits cannot leak in.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DATA_W-1:0] a_k;
        logic signed [DATA_W-1:0] b_k;
        logic                     lane_on;

        assign a_k       = bus.in_a[k*DATA_W +: DATA_W];
        assign b_k       = bus.in_b[k*DATA_W +: DATA_W];
        assign lane_on   = (int'(beat_cnt) * LANES + k) < IN_DIM;
        assign prod_c[k] = lane_on ? PROD_W'(a_k) * PROD_W'(b_k) : '0;
    end

    // Stage 1: capture the masked lane products of each transferred beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                s1_prod[k] <= '0;
            end
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                for (int k = 0; k < LANES; k++) begin
                    s1_prod[k] <= prod_c[k];
                end
                s1_first <= (beat_cnt == '0);
            end
        end
    end

    // Full-precision sum of the stage-1 products, each sign-extended first.
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_c = sum_c + ACC_W'(s1_prod[k]);
        end
    end

    // Stage 2: register the per-beat sum with its first-beat marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum   <= '0;
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= sum_c;
                s2_first <= s1_first;
            end
        end
    end

    // Beat 0 restarts the running sum; later beats add onto it.
    assign acc_next = s2_first ? s2_sum : acc + s2_sum;

    // Accumulator: updated once per beat leaving stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (s2_valid) begin
            acc <= acc_next;
        end
    end

`ifdef DOTPROD_STREAM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clip the finished sum into the signed OUT_W range.
    always_comb begin
        res_data = acc_next[OUT_W-1:0];
        res_sat  = 1'b0;
        if (acc_next > SAT_MAX) begin
            res_data = SAT_MAX[OUT_W-1:0];
            res_sat  = 1'b1;
        end else if (acc_next < SAT_MIN) begin
            res_data = SAT_MIN[OUT_W-1:0];
            res_sat  = 1'b1;
        end
    end
`else
    assign res_data = acc_next[OUT_W-1:0];
    assign res_sat  = 1'b0;
`endif

    // Control: accept beats, wait two cycles for the pipeline to empty, then
    // hold the registered result until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ACCEPT;
            beat_cnt      <= '0;
            drain_cnt     <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
        end else begin
            case (state)
                ACCEPT: begin
                    bus.in_ready <= 1'b1;
                    if (in_fire) begin
                        if (last_beat) begin
                            state        <= DRAIN;
                            beat_cnt     <= '0;
                            drain_cnt    <= 1'b0;
                            bus.in_ready <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    bus.in_ready <= 1'b0;
                    if (drain_cnt) begin
                        // The final beat leaves stage 2 now; acc_next is the answer.
                        state         <= HOLD;
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= res_data;
                        bus.out_sat   <= res_sat;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                HOLD: begin
                    bus.in_ready <= 1'b0;
                    if (out_fire) begin
                        state         <= ACCEPT;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= ACCEPT;
                    beat_cnt      <= '0;
                    bus.in_ready  <= 1'b0;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dotprod_stream.sv
// Bench for dotprod_stream: a 5-element, 2-lane, 16-bit-result instance plus
// a single-beat (4 lanes of 4 elements) instance. Expected results come from a
// plain integer dot product, then clipped or wrapped to 16 bits.
module tb_dotprod_stream;

    localparam int DW    = 8;
    localparam int DIM   = 5;
    localparam int LN    = 2;
    localparam int OW    = 16;
    localparam int BEATS = 3;
    localparam int DIM1  = 4;
    localparam int LN1   = 4;

    typedef int vec_t [DIM];
    typedef int vec1_t [DIM1];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] dbg0;
    logic [1:0] dbg1;

    int n_checks = 0;
    int n_errors = 0;

    logic [OW-1:0] exp_q[$];
    logic          sat_q[$];

    // clock / reset
    always #5 clk = ~clk;

    dotprod_stream_if #(.DATA_W(DW), .LANES(LN), .OUT_W(OW)) bus0 ();
    dotprod_stream_if #(.DATA_W(DW), .LANES(LN1), .OUT_W(OW)) bus1 ();

    dotprod_stream #(.DATA_W(DW), .IN_DIM(DIM), .LANES(LN), .OUT_W(OW)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0)
    );

    dotprod_stream #(.DATA_W(DW), .IN_DIM(DIM1), .LANES(LN1), .OUT_W(OW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1)
    );

    // reference model
    function automatic longint model_dot(input vec_t a, input vec_t b);
        longint s = 0;
        for (int i = 0; i < DIM; i++) s += longint'(a[i]) * longint'(b[i]);
        return s;
    endfunction

    function automatic logic [OW:0] model_out(input longint acc);
`ifdef DOTPROD_STREAM_SAT_EN
        longint hi = (longint'(1) <<< (OW - 1)) - 1;
        longint lo = -(longint'(1) <<< (OW - 1));
        if (acc > hi) return {1'b1, OW'(hi)};
        if (acc < lo) return {1'b1, OW'(lo)};
`endif
        return {1'b0, OW'(acc)};
    endfunction

    function automatic logic [LN*DW-1:0] pack0(input vec_t v, input int j, input int pad);
        logic [LN*DW-1:0] r = '0;
        for (int k = 0; k < LN; k++) begin
            int idx = j * LN + k;
            r[k*DW +: DW] = DW'((idx < DIM) ? v[idx] : pad);
        end
        return r;
    endfunction

    function automatic logic [LN1*DW-1:0] pack1(input vec1_t v);
        logic [LN1*DW-1:0] r = '0;
        for (int k = 0; k < LN1; k++) r[k*DW +: DW] = DW'(v[k]);
        return r;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // driver tasks
    task automatic drive_beat0(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b, output bit ok);
        int n = 0;
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.in_a = a;
        bus0.in_b = b;
        while (bus0.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (bus0.in_ready === 1'b1);
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus0.in_a = (LN*DW)'($urandom);
        bus0.in_b = (LN*DW)'($urandom);
    endtask

    task automatic send_vec0(input vec_t a, input vec_t b, input int gap, input int pad, output bit ok);
        bit o;
        ok = 1'b1;
        for (int j = 0; j < BEATS; j++) begin
            if (j > 0) repeat (gap) @(negedge clk);
            drive_beat0(pack0(a, j, pad), pack0(b, j, pad), o);
            ok = ok & o;
        end
    endtask

    task automatic recv0(input int hold, output logic [OW-1:0] d, output logic s, output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus0.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (bus0.out_valid === 1'b1);
        repeat (hold) @(negedge clk);
        d = bus0.out_data;
        s = bus0.out_sat;
        bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        bus0.in_valid = 1'b1;
        bus0.in_a = (LN*DW)'($urandom);
        bus0.in_b = (LN*DW)'($urandom);
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0 || dbg0 !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b state=%0d, expected 0 0 0",
                     bus0.in_ready, bus0.out_valid, dbg0);
        end
        n_checks++;
        if (bus0.out_data !== '0 || bus0.out_sat !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data: out_data=%h out_sat=%b, expected 0 0", bus0.out_data, bus0.out_sat);
        end
        bus0.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus0.in_ready !== 1'b1 || bus1.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release: in_ready=%b/%b, expected 1/1", bus0.in_ready, bus1.in_ready);
        end
    endtask

    task automatic test_basic();
        vec_t a = '{1, 2, 3, 4, 5};
        vec_t b = '{1, 1, 1, 1, 1};
        logic [OW:0] e = model_out(model_dot(a, b));
        logic [OW-1:0] d;
        logic s;
        bit ok;
        send_vec0(a, b, 0, 99, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL basic_accept: beat not accepted, got ok=0 expected 1");
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus0.out_valid !== (i == 3) || bus0.in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL basic_latency: cycle %0d out_valid=%b in_ready=%b, expected %b 0",
                         i, bus0.out_valid, bus0.in_ready, (i == 3));
            end
        end
        recv0(0, d, s, ok);
        n_checks++;
        if (!ok || d !== e[OW-1:0] || s !== e[OW]) begin
            n_errors++;
            $display("FAIL basic_data: got %0d sat %b, expected %0d sat %b",
                     $signed(d), s, $signed(e[OW-1:0]), e[OW]);
        end
    endtask

    task automatic test_saturation();
        vec_t a = '{-128, -128, -128, -128, -128};
        logic [OW:0] e = model_out(model_dot(a, a));
        logic [OW-1:0] d;
        logic s;
        bit ok;
        bit ok2;
        send_vec0(a, a, 0, rnd8(), ok);
        recv0(1, d, s, ok2);
        n_checks++;
        if (!ok || !ok2 || d !== e[OW-1:0] || s !== e[OW]) begin
            n_errors++;
            $display("FAIL saturation: got %0d sat %b, expected %0d sat %b",
                     $signed(d), s, $signed(e[OW-1:0]), e[OW]);
        end
    endtask

    task automatic test_gaps_hold();
        vec_t a = '{-3, 7, 0, 2, -1};
        vec_t b = '{4, -2, 9, 5, 6};
        logic [OW:0] e = model_out(model_dot(a, b));
        bit ok;
        int n = 0;
        send_vec0(a, b, 2, rnd8(), ok);
        @(negedge clk);
        while (bus0.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        // offer a stray beat while the result waits; it must be ignored
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if (!ok || bus0.out_valid !== 1'b1 || bus0.out_data !== e[OW-1:0] || bus0.out_sat !== e[OW]) begin
                n_errors++;
                $display("FAIL gaps_hold: cycle %0d valid=%b data=%0d, expected 1 %0d",
                         i, bus0.out_valid, $signed(bus0.out_data), $signed(e[OW-1:0]));
            end
        end
        bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL gaps_release: out_valid=%b in_ready=%b, expected 0 1",
                     bus0.out_valid, bus0.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        vec_t a = '{1, 1, 1, 1, 1};
        vec_t b = '{2, 2, 2, 2, 2};
        logic [OW:0] e = model_out(model_dot(a, b));
        logic [OW-1:0] d;
        logic s;
        bit ok;
        bit ok2;
        bit seen = 1'b0;
        drive_beat0((LN*DW)'($urandom), (LN*DW)'($urandom), ok);
        drive_beat0((LN*DW)'($urandom), (LN*DW)'($urandom), ok);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus0.in_ready !== 1'b0 || bus0.out_valid !== 1'b0 || dbg0 !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_async: in_ready=%b out_valid=%b state=%0d, expected 0 0 0",
                     bus0.in_ready, bus0.out_valid, dbg0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus0.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_discard: out_valid seen=%b, expected 0", seen);
        end
        send_vec0(a, b, 0, rnd8(), ok);
        recv0(0, d, s, ok2);
        n_checks++;
        if (!ok || !ok2 || d !== e[OW-1:0] || s !== e[OW]) begin
            n_errors++;
            $display("FAIL reset_next: got %0d sat %b, expected %0d sat %b",
                     $signed(d), s, $signed(e[OW-1:0]), e[OW]);
        end
    endtask

    task automatic test_random();
        vec_t a;
        vec_t b;
        logic [OW:0] e;
        logic [OW-1:0] d;
        logic s;
        logic [OW-1:0] ed;
        logic es;
        bit ok;
        bit ok2;
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < DIM; i++) begin
                a[i] = rnd8();
                b[i] = rnd8();
            end
            if (t == 0) begin
                for (int i = 0; i < DIM; i++) begin
                    a[i] = 127;
                    b[i] = -128;
                end
            end
            e = model_out(model_dot(a, b));
            exp_q.push_back(e[OW-1:0]);
            sat_q.push_back(e[OW]);
            send_vec0(a, b, int'($urandom_range(0, 2)), rnd8(), ok);
            bus0.in_valid = 1'($urandom_range(0, 1));
            recv0(int'($urandom_range(0, 3)), d, s, ok2);
            bus0.in_valid = 1'b0;
            ed = exp_q.pop_front();
            es = sat_q.pop_front();
            n_checks++;
            if (!ok || !ok2 || d !== ed || s !== es) begin
                n_errors++;
                $display("FAIL random_%0d: got %0d sat %b, expected %0d sat %b",
                         t, $signed(d), s, $signed(ed), es);
            end
        end
    endtask

    task automatic test_single_beat();
        vec1_t a1 = '{1, 2, 3, 4};
        vec1_t b1 = '{1, 1, 1, 1};
        vec1_t a2 = '{2, 2, 2, 2};
        vec1_t b2 = '{-1, -1, -1, -1};
        logic [OW-1:0] e1 [2];
        int acc_n = 0;
        int out_n = 0;
        bit will_acc;
        longint s0 = 0;
        longint s1 = 0;
        for (int i = 0; i < DIM1; i++) begin
            s0 += a1[i] * b1[i];
            s1 += a2[i] * b2[i];
        end
        e1[0] = OW'(s0);
        e1[1] = OW'(s1);
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.in_a = pack1(a1);
        bus1.in_b = pack1(b1);
        bus1.in_valid = 1'b1;
        for (int c = 0; c < 40 && out_n < 2; c++) begin
            if (c > 0) @(negedge clk);
            will_acc = bus1.in_valid && bus1.in_ready;
            if (dbg1 !== 2'd0) begin
                n_checks++;
                if (bus1.in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_ready: state=%0d in_ready=%b, expected 0", dbg1, bus1.in_ready);
                end
            end
            if (bus1.out_valid === 1'b1) begin
                n_checks++;
                if (bus1.out_data !== e1[out_n]) begin
                    n_errors++;
                    $display("FAIL single_data_%0d: got %0d, expected %0d",
                             out_n, $signed(bus1.out_data), $signed(e1[out_n]));
                end
                out_n++;
            end
            @(posedge clk);
            #1;
            if (will_acc) begin
                acc_n++;
                if (acc_n == 1) begin
                    bus1.in_a = pack1(a2);
                    bus1.in_b = pack1(b2);
                end else begin
                    bus1.in_valid = 1'b0;
                end
            end
        end
        bus1.in_valid = 1'b0;
        bus1.out_ready = 1'b0;
        n_checks++;
        if (out_n != 2 || acc_n != 2) begin
            n_errors++;
            $display("FAIL single_count: outputs %0d beats %0d, expected 2 2", out_n, acc_n);
        end
    endtask

    // watchdog
    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        bus0.in_valid = 1'b0;
        bus0.in_a = '0;
        bus0.in_b = '0;
        bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0;
        bus1.in_a = '0;
        bus1.in_b = '0;
        bus1.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturation();
        test_gaps_hold();
        test_reset_mid();
        test_random();
        test_single_beat();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dotprod_stream.md
DOTPROD_STREAM -- requirements
Module: dotprod_stream

Interface
REQ-001 Parameter DATA_W, default 16: signed element width in bits.
REQ-002 Parameter IN_DIM, default 8: vector length (elements per dot product), >= 1.
REQ-003 Parameter LANES, default 4: elements accepted per beat, 1 <= LANES <= IN_DIM.
REQ-004 Parameter OUT_W, default 32: signed result width, <= ACC_W.
REQ-005 Derived ACC_W = 2*DATA_W + clog2(IN_DIM)+1. Derived BEATS = ceil(IN_DIM/LANES).
REQ-006 clk  input  1  the only clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  a beat is offered on in_a/in_b.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 in_a  input  LANES*DATA_W  packed signed elements of A; lane k at bits [k*DATA_W +: DATA_W].
REQ-011 in_b  input  LANES*DATA_W  packed signed elements of B, same packing.
REQ-012 out_valid  output  1  result held on out_data.
REQ-013 out_ready  input  1  consumer takes the result.
REQ-014 out_data  output  OUT_W  signed dot product.
REQ-015 out_sat  output  1  result was clipped (see REQ-031).

Function
REQ-016 A beat transfers when in_valid && in_ready; an output transfers when out_valid && out_ready.
REQ-017 Beat index j (0..BEATS-1) carries elements j*LANES+k; on beat BEATS-1, lanes with index >= IN_DIM shall contribute zero regardless of input.
REQ-018 Stage 1 (registered): LANES signed products, each 2*DATA_W bits, masked per REQ-017.
REQ-019 Stage 2 (registered): full-precision signed sum of the stage-1 products, sign-extended to ACC_W.
REQ-020 Accumulator (ACC_W) loads the stage-2 sum for beat 0 and adds it for beats 1..BEATS-1; no intermediate overflow.
REQ-021 FSM states ACCEPT, DRAIN, HOLD. Reset -> ACCEPT.
REQ-022 ACCEPT: in_ready=1; beat counter increments per transfer; transfer of beat BEATS-1 -> DRAIN and counter clears to 0.
REQ-023 DRAIN: in_ready=0; lasts exactly 2 cycles while the final beat passes stages 1-2 and the accumulator; then -> HOLD with out_valid=1.
REQ-024 Latency: out_valid rises 3 cycles after the clock edge that accepts the final beat.
REQ-025 HOLD: in_ready=0; out_data/out_sat stable until output transfer; on transfer -> ACCEPT with out_valid=0 next cycle.
REQ-026 in_valid low in ACCEPT stalls without losing the partial sum or beat count; bubbles between beats are permitted.
REQ-027 in_valid asserted during DRAIN/HOLD has no effect; in_a/in_b ignored when not transferring.
REQ-028 BEATS=1: every transfer goes straight to DRAIN; counter stays 0.

Reset
REQ-029 While rst_n=0, regardless of clk: state=ACCEPT, beat counter=0, stage registers=0, accumulator=0, out_valid=0, out_data=0, out_sat=0, in_ready=0.
REQ-030 in_ready shall be 1 from the first clk edge after rst_n deasserts; reset mid-vector or mid-HOLD discards all partial and pending results.

Configuration
REQ-031 Macro DOTPROD_STREAM_SAT_EN defined: out_data = accumulator clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], out_sat=1 iff clipping occurred; not defined: out_data = low OUT_W bits of accumulator (two's-complement wrap), out_sat tied 0.

Verification (DATA_W=8, IN_DIM=5, LANES=2, OUT_W=16 unless noted)
REQ-032 A=[1,2,3,4,5], B=[1,1,1,1,1] in 3 back-to-back beats, lane 1 of beat 2 set to 99/99 -> out_data=15, out_valid exactly 3 cycles after beat-2 accept, in_ready=0 during DRAIN/HOLD.
REQ-033 A=[-128 x5], B=[-128 x5], OUT_W=16 -> accumulator 81920; with SAT_EN out_data=32767, out_sat=1; without, out_data=16384, out_sat=0.
REQ-034 A=[-3,7,0,2,-1], B=[4,-2,9,5,6], idle gaps of 2 cycles between beats, out_ready low 4 cycles in HOLD -> out_data=-22 held stable, single output transfer, then in_ready=1.
REQ-035 rst_n pulled low after beat 1 of vector X, then vector [1 x5]·[2 x5] sent -> no output for X, out_data=10.
REQ-036 IN_DIM=4, LANES=4 (BEATS=1), two vectors [1,2,3,4]·[1,1,1,1] then [2,2,2,2]·[-1,-1,-1,-1], out_ready=1 -> outputs 10 then -8 in order, no beat accepted in DRAIN/HOLD.
